// File: rtl/image_pipe_proc.sv
// image_pipe_proc: elastic FIFO plus per-pixel op unit between image pipe stages, programmed over reg_cpu.
// Optional frame/stall statistics counters are built when IMAGE_PIPE_PROC_STATS_EN is defined.
module image_pipe_proc #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] image_pipe_data_in,
  input  logic          image_pipe_valid_in,
  input  logic          image_pipe_end_in,
  output logic          image_pipe_busy_out,
  output logic [DW-1:0] image_pipe_data_out,
  output logic          image_pipe_valid_out,
  output logic          image_pipe_end_out,
  input  logic          image_pipe_busy_in,
  input  logic          reg_cpu_cs,
  input  logic          reg_cpu_we,
  input  logic          reg_cpu_re,
  input  logic [29:0]   reg_cpu_addr,
  input  logic [31:0]   reg_cpu_data_wr,
  output logic [31:0]   reg_cpu_data_rd,
  output logic          reg_cpu_wack,
  output logic          reg_cpu_rdv
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DW:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_next;
  logic           push, pop, wr_en, re_q;
  logic           ctrl_en;
  logic [1:0]     ctrl_mode, mode;
  logic [31:0]    offset, thresh, rd_mux;
  logic [15:0]    frame_cnt, stall_cnt;
  logic [13:0]    addr;
  logic [DW:0]    head, sum;
  logic [DW-1:0]  op_data;
  logic           unused_bits;
  assign addr        = reg_cpu_addr[13:0];
  assign wr_en       = reg_cpu_cs & reg_cpu_we;
  assign push        = image_pipe_valid_in & ~image_pipe_busy_out;
  assign pop         = (count != '0) & (~image_pipe_valid_out | ~image_pipe_busy_in);
  assign count_next  = count + (AW+1)'(push) - (AW+1)'(pop);
  assign head        = mem[rd_ptr];
  assign mode        = ctrl_en ? ctrl_mode : 2'd0;
  assign sum         = {1'b0, head[DW-1:0]} + {1'b0, offset[DW-1:0]};
  assign unused_bits = ^{reg_cpu_addr[29:14], offset, thresh};
  always_comb
    op_data = (mode == 2'd1) ? ~head[DW-1:0] :
              (mode == 2'd2) ? (sum[DW] ? {DW{1'b1}} : sum[DW-1:0]) :
              (mode == 2'd3) ? ((head[DW-1:0] >= thresh[DW-1:0]) ? {DW{1'b1}} : {DW{1'b0}}) :
              head[DW-1:0];
  always_comb
    rd_mux = (addr == 14'd0) ? {29'd0, ctrl_mode, ctrl_en} :
             (addr == 14'd1) ? offset :
             (addr == 14'd2) ? thresh :
             (addr == 14'd3) ? {16'd0, frame_cnt} :
             (addr == 14'd4) ? {16'd0, stall_cnt} : 32'd0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {image_pipe_end_in, image_pipe_data_in};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      image_pipe_busy_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count               <= count_next;
      image_pipe_busy_out <= (count_next == FULL);
    end
  // output stage holds under downstream stall, drains to idle otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      image_pipe_data_out  <= '0;
      image_pipe_valid_out <= 1'b0;
      image_pipe_end_out   <= 1'b0;
    end else if (pop) begin
      image_pipe_data_out  <= op_data;
      image_pipe_valid_out <= 1'b1;
      image_pipe_end_out   <= head[DW];
    end else if (!image_pipe_busy_in) begin
      image_pipe_valid_out <= 1'b0;
      image_pipe_end_out   <= 1'b0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctrl_en   <= 1'b1;
      ctrl_mode <= 2'd0;
      offset    <= '0;
      thresh    <= '0;
    end else if (wr_en) begin
      if (addr == 14'd0) {ctrl_mode, ctrl_en} <= reg_cpu_data_wr[2:0];
      if (addr == 14'd1) offset <= reg_cpu_data_wr;
      if (addr == 14'd2) thresh <= reg_cpu_data_wr;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      reg_cpu_wack    <= 1'b0;
      reg_cpu_rdv     <= 1'b0;
      re_q            <= 1'b0;
      reg_cpu_data_rd <= '0;
    end else begin
      reg_cpu_wack <= wr_en;
      reg_cpu_rdv  <= reg_cpu_cs & reg_cpu_re;
      re_q         <= reg_cpu_re;
      if (reg_cpu_cs && reg_cpu_re && !re_q) reg_cpu_data_rd <= rd_mux;
    end
`ifdef IMAGE_PIPE_PROC_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else if (wr_en && addr == 14'd3) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (image_pipe_valid_out && image_pipe_end_out && !image_pipe_busy_in) frame_cnt <= frame_cnt + 16'd1;
      if (image_pipe_valid_in && image_pipe_busy_out) stall_cnt <= stall_cnt + 16'd1;
    end
`else
  assign frame_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule
